// File: rtl/uart_pkg.sv
// Shared types for the round-robin uart transmit scheduler.
package uart_pkg;
  localparam int CFG_W = 7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} sched_state_e;

  typedef struct packed {
    logic [3:0] length;
    logic       parity_type;
    logic       parity_en;
    logic       stop2;
  } uart_cfg_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart transmitter among NUM_REQ requesters: grant, hold the frame
// on the uart inputs until the synchronized done edge or a timeout, then idle a gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 1048576,
  parameter int GAP_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  input  logic [CFG_W*NUM_REQ-1:0]   req_cfg_i,
  output logic                       tx_start_o,
  output logic [7:0]                 tx_data_o,
  output logic [3:0]                 length_o,
  output logic                       parity_type_o,
  output logic                       parity_en_o,
  output logic                       stop2_o,
  input  logic                       tx_done_i,
  input  logic                       tx_err_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(NUM_REQ)-1:0] done_id_o,
  output logic                       err_o,
  output logic                       timeout_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  sched_state_e                  state;
  logic [IW-1:0]                 rr_ptr, win_idx, id_q;
  logic [NUM_REQ-1:0]            win_gnt;
  logic                          win_any;
  logic [NUM_REQ-1:0][7:0]       data_arr;
  logic [NUM_REQ-1:0][CFG_W-1:0] cfg_arr;
  uart_cfg_t                     cfg_q;
  // [1:0] are the synchronizer, [2] is the edge-detect register
  logic [2:0]                    done_pipe;
  logic [1:0]                    err_pipe;
  logic                          armed, err_seen;
  logic [TW-1:0]                 tcnt;
  logic [GW-1:0]                 gcnt;
  logic                          complete, tmo;

  assign data_arr = req_data_i;
  assign cfg_arr  = req_cfg_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Grant only in IDLE; reset forces every output low, including this one.
  assign req_ready_o = (state == S_IDLE && rst_ni) ? win_gnt : '0;
  assign busy_o      = (state != S_IDLE);

  assign length_o      = cfg_q.length;
  assign parity_type_o = cfg_q.parity_type;
  assign parity_en_o   = cfg_q.parity_en;
  assign stop2_o       = cfg_q.stop2;

  // armed rejects a done level left high from the previous frame
  assign complete = armed & done_pipe[1] & ~done_pipe[2];
  assign tmo      = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      cfg_q      <= '0;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      done_pipe  <= '0;
      err_pipe   <= '0;
      armed      <= 1'b0;
      err_seen   <= 1'b0;
      tcnt       <= '0;
      gcnt       <= '0;
      done_o     <= 1'b0;
      done_id_o  <= '0;
      err_o      <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      done_pipe <= {done_pipe[1:0], tx_done_i};
      err_pipe  <= {err_pipe[0], tx_err_i};
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: if (win_any) begin
          tx_data_o  <= data_arr[win_idx];
          cfg_q      <= cfg_arr[win_idx];
          id_q       <= win_idx;
          rr_ptr     <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          tx_start_o <= 1'b1;
          armed      <= 1'b0;
          err_seen   <= 1'b0;
          tcnt       <= '0;
          state      <= S_BUSY;
        end
        S_BUSY: begin
          if (!done_pipe[1]) armed    <= 1'b1;
          if (err_pipe[1])   err_seen <= 1'b1;
          if (complete || tmo) begin
            tx_start_o <= 1'b0;
            done_o     <= 1'b1;
            done_id_o  <= id_q;
            err_o      <= complete ? (err_pipe[1] | err_seen) : 1'b1;
            timeout_o  <= ~complete;
            gcnt       <= '0;
            state      <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP_CYCLES)) state <= S_IDLE;
          else                         gcnt  <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
